// File: rtl/axi_rd_sram_bridge.sv
// AXI4 read-only slave: turns AR bursts into single-beat reads of a 1-cycle-latency SRAM.
// R channel is fed from a 2-entry skid FIFO with flow-through of the SRAM read data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arready high, waiting for an AR handshake
// ST_BURST | issuing SRAM reads and returning R beats until rlast handshake
module axi_rd_sram_bridge #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [ID_W-1:0]   axi_arid_i,
    input  logic [ADDR_W-1:0] axi_araddr_i,
    input  logic [7:0]        axi_arlen_i,
    input  logic [2:0]        axi_arsize_i,
    input  logic [1:0]        axi_arburst_i,
    input  logic              axi_arvalid_i,
    output logic              axi_arready_o,
    output logic [ID_W-1:0]   axi_rid_o,
    output logic [DATA_W-1:0] axi_rdata_o,
    output logic [1:0]        axi_rresp_o,
    output logic              axi_rlast_o,
    output logic              axi_rvalid_o,
    input  logic              axi_rready_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ren_o,
    input  logic [DATA_W-1:0] sram_data_i
);
    localparam logic       ST_IDLE  = 1'b0;
    localparam logic       ST_BURST = 1'b1;
    localparam logic [1:0] K_FIXED  = 2'b00;
    localparam logic [1:0] K_INCR   = 2'b01;
    localparam logic [1:0] K_WRAP   = 2'b10;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));

    logic              state, state_next, arready;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q, sram_addr_q;
    logic [7:0]        len_q, beats_q;
    logic [2:0]        size_q;
    logic [1:0]        kind_q, kind_in;
    logic              err_q, err_in, wrap_len_ok;
    logic [8:0]        issued_q;
    logic              ren_q, data_vld;
    logic [DATA_W-1:0] mem [0:1];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        cnt;
    logic [2:0]        occ;
    logic              ar_hs, pop, push, rvalid, is_last, can_issue;
    logic [DATA_W-1:0] head;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [7:0] len,
                                                    input logic [1:0] kind);
        logic [ADDR_W-1:0] bytes, mask;
        bytes = ADDR_W'(1) << size;
        mask  = (ADDR_W'(len) << size) | (bytes - ADDR_W'(1));
        case (kind)
            K_FIXED: return a;
            K_WRAP:  return (a & ~mask) | ((a + bytes) & mask);
            default: return (a & ~(bytes - ADDR_W'(1))) + bytes;
        endcase
    endfunction

    // Reserved bursts and illegal WRAP lengths fall back to INCR addressing but report SLVERR.
    always_comb begin
        wrap_len_ok = (axi_arlen_i == 8'd1) || (axi_arlen_i == 8'd3) ||
                      (axi_arlen_i == 8'd7) || (axi_arlen_i == 8'd15);
        kind_in = K_INCR;
        if (axi_arburst_i == K_FIXED)
            kind_in = K_FIXED;
        else if (axi_arburst_i == K_WRAP && wrap_len_ok)
            kind_in = K_WRAP;
        err_in = (axi_arsize_i > MAX_SIZE) || (axi_arburst_i == 2'b11) ||
                 (axi_arburst_i == K_WRAP && !wrap_len_ok);
    end

    // Occupancy counts stored beats, the beat arriving now and the read issued this cycle.
    always_comb begin
        ar_hs     = axi_arvalid_i && arready;
        rvalid    = (cnt != 2'd0) || data_vld;
        head      = (cnt != 2'd0) ? mem[rd_ptr] : sram_data_i;
        pop       = rvalid && axi_rready_i;
        push      = data_vld && !(cnt == 2'd0 && pop);
        is_last   = (beats_q == len_q);
        occ       = {1'b0, cnt} + {2'b0, data_vld} + {2'b0, ren_q} - {2'b0, pop};
        can_issue = (state == ST_BURST) && (issued_q <= {1'b0, len_q}) && (occ < 3'd2);
        state_next = state;
        if (state == ST_IDLE && ar_hs)
            state_next = ST_BURST;
        else if (state == ST_BURST && pop && is_last)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= ST_IDLE;
            arready     <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            kind_q      <= K_INCR;
            err_q       <= 1'b0;
            issued_q    <= '0;
            beats_q     <= '0;
            ren_q       <= 1'b0;
            sram_addr_q <= '0;
            data_vld    <= 1'b0;
        end else begin
            state    <= state_next;
            arready  <= (state_next == ST_IDLE);
            data_vld <= ren_q;
            if (ar_hs) begin
                id_q        <= axi_arid_i;
                len_q       <= axi_arlen_i;
                size_q      <= axi_arsize_i;
                kind_q      <= kind_in;
                err_q       <= err_in;
                beats_q     <= '0;
                issued_q    <= 9'd1;
                ren_q       <= 1'b1;
                sram_addr_q <= axi_araddr_i;
                addr_q      <= next_addr(axi_araddr_i, axi_arsize_i, axi_arlen_i, kind_in);
            end else begin
                ren_q <= can_issue;
                if (can_issue) begin
                    sram_addr_q <= addr_q;
                    addr_q      <= next_addr(addr_q, size_q, len_q, kind_q);
                    issued_q    <= issued_q + 9'd1;
                end
                if (pop)
                    beats_q <= beats_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sram_data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop && cnt != 2'd0)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, push} - {1'b0, (pop && cnt != 2'd0)};
        end
    end

    assign axi_arready_o = arready;
    assign axi_rvalid_o  = rvalid;
    assign axi_rdata_o   = rvalid ? head : '0;
    assign axi_rid_o     = id_q;
    assign axi_rresp_o   = err_q ? 2'b10 : 2'b00;
    assign axi_rlast_o   = rvalid && is_last;
    assign sram_addr_o   = sram_addr_q;
    assign sram_ren_o    = ren_q;

endmodule

// File: tb/tb_axi_rd_sram_bridge.sv
// Self-checking bench for axi_rd_sram_bridge: directed and random bursts against a
// closed-form address/response model and a hashed SRAM content model.
module tb_axi_rd_sram_bridge;
    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [31:0] sram_addr;
    logic        sram_ren;
    logic [31:0] sram_data = 32'h0;

    always #5 clk = ~clk;

    axi_rd_sram_bridge #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arsize_i(arsize), .axi_arburst_i(arburst),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .sram_addr_o(sram_addr), .sram_ren_o(sram_ren), .sram_data_i(sram_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    always @(posedge clk)
        if (sram_ren) sram_data <= mem_word(sram_addr);

    // Monitor: records SRAM reads and R handshakes, tracks stall stability and outstanding reads.
    typedef struct {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        int          c;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] ren_addr[$];
    int          ren_cyc[$];
    int          cyc = 0, stall_err = 0, max_out = 0, ren_n = 0, pop_n = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [3:0]  prev_id;
    logic [1:0]  prev_resp;
    logic        prev_last;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstn) begin
            ren_n      <= 0;
            pop_n      <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!rvalid || rdata !== prev_data || rid !== prev_id ||
                               rresp !== prev_resp || rlast !== prev_last))
                stall_err <= stall_err + 1;
            if (sram_ren) begin
                ren_addr.push_back(sram_addr);
                ren_cyc.push_back(cyc);
            end
            if (rvalid && rready)
                beats.push_back(beat_t'{rdata, rid, rresp, rlast, cyc});
            ren_n <= ren_n + int'(sram_ren);
            pop_n <= pop_n + int'(rvalid && rready);
            if (ren_n + int'(sram_ren) - pop_n - int'(rvalid && rready) > max_out)
                max_out <= ren_n + int'(sram_ren) - pop_n - int'(rvalid && rready);
            prev_stall <= rvalid && !rready;
            prev_data  <= rdata;
            prev_id    <= rid;
            prev_resp  <= rresp;
            prev_last  <= rlast;
        end
    end

    // Reference: address of beat i computed directly from the burst rules.
    function automatic logic [31:0] model_addr(input logic [31:0] a0, input int len,
                                               input int size, input int burst, input int i);
        longint bytes, wb, base;
        bytes = longint'(1) << size;
        if (burst == 0) return a0;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            wb   = (len + 1) * bytes;
            base = longint'(a0) - (longint'(a0) % wb);
            return 32'(base + ((longint'(a0) - base + i * bytes) % wb));
        end
        if (i == 0) return a0;
        return 32'((longint'(a0) / bytes) * bytes + i * bytes);
    endfunction

    function automatic logic model_err(input int len, input int size, input int burst);
        return (size > 2) || (burst == 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    endfunction

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_ar(input string nm, input logic [3:0] id, input logic [31:0] a,
                            input int len, input int size, input int burst,
                            output int t, output bit ok);
        @(posedge clk); #1;
        arid = id; araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        ok = 1'b0;
        t  = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; t = cyc; break; end
        end
        chk({nm, "_ar_wait"}, 64'(ok), 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        araddr  = $urandom;
    endtask

    task automatic run_burst(input string nm, input logic [3:0] id, input logic [31:0] a,
                             input int len, input int size, input int burst,
                             input bit rand_ready, input bit check_lat);
        int  b0, r0, t, n, nr;
        bit  ok;
        logic [31:0] ea;
        logic [1:0]  er;
        b0 = beats.size();
        r0 = ren_addr.size();
        rready = 1'b1;
        start_ar(nm, id, a, len, size, burst, t, ok);
        if (!ok) return;
        for (int k = 0; k < (len + 1) * 6 + 20 && beats.size() - b0 < len + 1; k++) begin
            rready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(negedge clk);
        chk({nm, "_arready_back"}, 64'(arready), 64'd1);
        n  = beats.size() - b0;
        nr = ren_addr.size() - r0;
        chk({nm, "_nbeats"}, 64'(n), 64'(len + 1));
        chk({nm, "_nreads"}, 64'(nr), 64'(len + 1));
        er = model_err(len, size, burst) ? 2'b10 : 2'b00;
        for (int i = 0; i <= len && i < n && i < nr; i++) begin
            ea = model_addr(a, len, size, burst, i);
            chk({nm, "_sram_addr"}, 64'(ren_addr[r0 + i]), 64'(ea));
            chk({nm, "_rdata"}, 64'(beats[b0 + i].data), 64'(mem_word(ea)));
            chk({nm, "_rid"}, 64'(beats[b0 + i].id), 64'(id));
            chk({nm, "_rresp"}, 64'(beats[b0 + i].resp), 64'(er));
            chk({nm, "_rlast"}, 64'(beats[b0 + i].last), 64'(i == len));
        end
        if (check_lat && n == len + 1 && nr > 0) begin
            chk({nm, "_ren_lat"}, 64'(ren_cyc[r0]), 64'(t + 1));
            chk({nm, "_rvalid_lat"}, 64'(beats[b0].c), 64'(t + 2));
            chk({nm, "_back2back"}, 64'(beats[b0 + len].c), 64'(t + 2 + len));
        end
    endtask

    initial begin
        int          t, b0, bsnap, len, size, burst;
        bit          ok;
        logic [31:0] a;
        rstn = 1'b0; arvalid = 1'b0; rready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        #2;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_sram_ren", 64'(sram_ren), 64'd0);
        #20 rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_arready", 64'(arready), 64'd1);

        run_burst("incr", 4'd3, 32'h100, 3, 2, 1, 1'b0, 1'b1);
        run_burst("wrap", 4'd1, 32'h38, 3, 2, 2, 1'b0, 1'b1);
        run_burst("bp", 4'd7, 32'h200, 7, 2, 1, 1'b1, 1'b0);
        chk("bp_stable", 64'(stall_err), 64'd0);
        chk("bp_outstanding", 64'(max_out <= 2), 64'd1);
        run_burst("err_size", 4'd2, 32'h400, 1, 3, 1, 1'b0, 1'b1);
        run_burst("err_wrap", 4'd4, 32'h500, 2, 2, 2, 1'b0, 1'b1);
        run_burst("err_rsvd", 4'd6, 32'h602, 2, 1, 3, 1'b1, 1'b0);
        run_burst("fixed256", 4'd9, 32'h40, 255, 2, 0, 1'b0, 1'b1);
        run_burst("incr_unal", 4'd10, 32'h703, 2, 2, 1, 1'b0, 1'b1);
        run_burst("top_wrap", 4'd11, 32'hFFFF_FFF8, 3, 2, 1, 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            size  = $urandom_range(0, 2);
            burst = $urandom_range(0, 2);
            len   = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 1) == 1) len = (2 << $urandom_range(0, 3)) - 1;
            a = $urandom & ~((32'd1 << size) - 32'd1);
            run_burst("rand", 4'($urandom), a, len, size, burst, 1'b1, 1'b0);
        end

        // Reset in the middle of an 8-beat burst, then a clean burst.
        rready = 1'b1;
        b0 = beats.size();
        start_ar("mid_rst", 4'd5, 32'h300, 7, 2, 1, t, ok);
        for (int k = 0; k < 40 && beats.size() - b0 < 2; k++) begin
            @(posedge clk); #1;
        end
        chk("mid_rst_two_beats", 64'(beats.size() - b0), 64'd2);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_arready", 64'(arready), 64'd0);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_rdata", 64'(rdata), 64'd0);
        chk("mid_rst_rid", 64'(rid), 64'd0);
        chk("mid_rst_rresp", 64'(rresp), 64'd0);
        chk("mid_rst_rlast", 64'(rlast), 64'd0);
        chk("mid_rst_sram_addr", 64'(sram_addr), 64'd0);
        chk("mid_rst_sram_ren", 64'(sram_ren), 64'd0);
        bsnap = beats.size();
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_arready_back", 64'(arready), 64'd1);
        repeat (3) @(negedge clk);
        chk("mid_rst_no_stale", 64'(beats.size()), 64'(bsnap));
        run_burst("after_rst", 4'd12, 32'h800, 5, 2, 1, 1'b0, 1'b1);

        chk("final_stable", 64'(stall_err), 64'd0);
        chk("final_outstanding", 64'(max_out <= 2), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
